memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 i_ex_valid  in  1  EX presents an instruction this cycle.
REQ-004 i_ex_result  in  32  ALU result; byte address for loads/stores.
REQ-005 i_ex_store_data  in  32  rs2 value for stores.
REQ-006 i_ex_mem_read  in  1  instruction is a load.
REQ-007 i_ex_mem_write  in  1  instruction is a store.
REQ-008 i_ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 i_ex_mem_to_reg  in  1  forwarded to WB mux select.
REQ-010 i_ex_rw_sel  in  2  forwarded to WB writeback source select.
REQ-011 i_ex_pc_plus_4  in  32  forwarded link value.
REQ-012 o_ex_stall  out  1  MA busy; EX SHALL hold its inputs stable while high.
REQ-013 o_dmem_req  out  1  data memory request, held until acknowledged.
REQ-014 o_dmem_we  out  1  1 = write, 0 = read.
REQ-015 o_dmem_addr  out  32  word address, bits [1:0] forced to 00.
REQ-016 o_dmem_be  out  4  byte-lane enables.
REQ-017 o_dmem_wdata  out  32  lane-aligned store data.
REQ-018 i_dmem_ack  in  1  one-cycle completion pulse; rdata valid in the same cycle.
REQ-019 i_dmem_rdata  in  32  raw read word.
REQ-020 o_ma_valid  out  1  one-cycle pulse per completed instruction.
REQ-021 o_ma_mem_to_reg  out  1  registered copy of i_ex_mem_to_reg.
REQ-022 o_ma_rw_sel  out  2  registered copy of i_ex_rw_sel.
REQ-023 o_ma_result  out  32  registered copy of i_ex_result.
REQ-024 o_ma_read_data  out  32  aligned, extended load data; 0 for non-loads.
REQ-025 o_ma_pc_plus_4  out  32  registered copy of i_ex_pc_plus_4.

Function
REQ-026 FSM states: IDLE and REQ. IDLE + i_ex_valid + (mem_read|mem_write) -> REQ; REQ + i_dmem_ack -> IDLE.
REQ-027 Non-memory instruction accepted in IDLE: o_ma_* registered; o_ma_valid high exactly the next cycle (latency 1).
REQ-028 Memory instruction: request fields registered on accept; o_dmem_req high from the next cycle until the ack cycle inclusive; o_ma_valid pulses the cycle after ack.
REQ-029 o_ex_stall = (state==REQ); i_ex_* ignored in REQ.
REQ-030 Store lanes: SB be=0001<<addr[1:0], byte replicated x4; SH be=0011<<(2*addr[1]), half replicated x2; SW be=1111.
REQ-031 Load extract: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW raw; other funct3 -> 0.
REQ-032 Loads set o_dmem_be=1111; misaligned halfword/word ignore the offending low bits (no trap).
REQ-033 Back-to-back: a new EX instruction is accepted in the same IDLE cycle that o_ma_valid is pulsed.
REQ-034 mem_read and mem_write both high: treated as a store.

Reset
REQ-035 Async assertion: state IDLE; o_dmem_req, o_ma_valid, o_ex_stall, and all o_ma_*/o_dmem_* buses 0; in-flight request abandoned; late ack ignored.

Configuration
REQ-036 MA_SUBWORD_EN defined: REQ-030/031 behaviour; undefined: every access is word (be=1111, wdata=store_data, read_data=rdata), funct3 ignored.

Structure
REQ-037 rv32i_pkg holds funct3 load/store constants and ma_state_t enum; submodule load_extract (combinational rdata/addr/funct3 -> read_data).

Verification
REQ-038 ADD result 0x00000010, no mem -> o_ma_valid next cycle, o_ma_result=0x10, o_dmem_req never high.
REQ-039 LB addr 0x103, rdata 0x80FF_FF7F, ack after 2 waits -> addr 0x100, read_data 0xFFFFFF80, stall 3 cycles.
REQ-040 SH addr 0x202, data 0x0000_BEEF, immediate ack -> be=1100, wdata 0xBEEFBEEF, we=1.
REQ-041 LHU addr 0x0, rdata 0x1234_8001 -> read_data 0x00008001; LH same -> 0xFFFF8001.
REQ-042 i_rst_n low during REQ, ack 1 cycle after release -> no o_ma_valid, state IDLE.
REQ-043 MA_SUBWORD_EN undefined, SB addr 0x1 data 0xAB -> be=1111, wdata 0x000000AB.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-stage definitions: load/store funct3 encodings, the
// memory-access FSM state type and store lane-placement helpers.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        MA_IDLE = 1'b0,
        MA_REQ  = 1'b1
    } ma_state_t;

    // Byte-lane enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B:    return 4'b0001 << lo;
            F3_H:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the datum across the word puts it on every lane the be may pick.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            F3_B:    return {4{data[7:0]}};
            F3_H:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master)
// and the data memory (slave).
interface memory_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/load_extract.sv
// Combinational load aligner: picks the addressed byte/half out of the raw read
// word and extends it. Subword selection only when MA_SUBWORD_EN is defined.
module load_extract
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] read_data_o
);

`ifdef MA_SUBWORD_EN
    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata_i[8*gi +: 8];
    end

    assign byte_sel = lane[addr_lo_i];
    // Misaligned halves ignore addr bit 0 and take the half named by bit 1.
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        read_data_o = '0;
        case (funct3_i)
            F3_B:    read_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    read_data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    read_data_o = rdata_i;
            F3_BU:   read_data_o = {24'b0, byte_sel};
            F3_HU:   read_data_o = {16'b0, half_sel};
            default: read_data_o = '0;
        endcase
    end
`else
    logic unused_ok;
    assign unused_ok   = &{1'b0, addr_lo_i, funct3_i};
    assign read_data_o = rdata_i;
`endif

endmodule

// File: rtl/memory_access.sv
// RV32I memory-access pipeline stage: issues one data-memory request per
// load/store, stalls EX until acknowledged. MA_SUBWORD_EN enables byte/half access.
module memory_access
    import rv32i_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_result,
    input  logic [31:0] i_ex_store_data,
    input  logic        i_ex_mem_read,
    input  logic        i_ex_mem_write,
    input  logic [2:0]  i_ex_funct3,
    input  logic        i_ex_mem_to_reg,
    input  logic [1:0]  i_ex_rw_sel,
    input  logic [31:0] i_ex_pc_plus_4,
    output logic        o_ex_stall,

    memory_access_if.master dmem,

    output logic        o_ma_valid,
    output logic        o_ma_mem_to_reg,
    output logic [1:0]  o_ma_rw_sel,
    output logic [31:0] o_ma_result,
    output logic [31:0] o_ma_read_data,
    output logic [31:0] o_ma_pc_plus_4
);

    ma_state_t   state_q, state_d;

    logic        accept;
    logic        is_mem;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_data;

    logic        ma_valid_q;
    logic        mem_to_reg_q;
    logic [1:0]  rw_sel_q;
    logic [31:0] result_q;
    logic [31:0] read_data_q;
    logic [31:0] pc_plus_4_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        is_load_q;
    logic [2:0]  funct3_q;

    assign accept = (state_q == MA_IDLE) && i_ex_valid;
    assign is_mem = i_ex_mem_read | i_ex_mem_write;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= MA_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MA_IDLE: if (accept && is_mem) state_d = MA_REQ;
            MA_REQ:  if (dmem.ack)         state_d = MA_IDLE;
            default:                       state_d = MA_IDLE;
        endcase
    end

    // A store wins when both mem_read and mem_write are asserted.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = '0;
`ifdef MA_SUBWORD_EN
        if (i_ex_mem_write) begin
            be_d    = store_be(i_ex_funct3, i_ex_result[1:0]);
            wdata_d = store_wdata(i_ex_funct3, i_ex_store_data);
        end
`else
        if (i_ex_mem_write) wdata_d = i_ex_store_data;
`endif
    end

    load_extract u_load_extract (
        .rdata_i     (dmem.rdata),
        .addr_lo_i   (result_q[1:0]),
        .funct3_i    (funct3_q),
        .read_data_o (load_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ma_valid_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rw_sel_q     <= '0;
            result_q     <= '0;
            read_data_q  <= '0;
            pc_plus_4_q  <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            is_load_q    <= 1'b0;
            funct3_q     <= '0;
        end else begin
            ma_valid_q <= 1'b0;
            if (accept) begin
                mem_to_reg_q <= i_ex_mem_to_reg;
                rw_sel_q     <= i_ex_rw_sel;
                result_q     <= i_ex_result;
                pc_plus_4_q  <= i_ex_pc_plus_4;
                read_data_q  <= '0;
                if (is_mem) begin
                    we_q      <= i_ex_mem_write;
                    addr_q    <= {i_ex_result[31:2], 2'b00};
                    be_q      <= be_d;
                    wdata_q   <= wdata_d;
                    is_load_q <= i_ex_mem_read & ~i_ex_mem_write;
                    funct3_q  <= i_ex_funct3;
                end else begin
                    ma_valid_q <= 1'b1;
                end
            end else if ((state_q == MA_REQ) && dmem.ack) begin
                ma_valid_q  <= 1'b1;
                read_data_q <= is_load_q ? load_data : 32'h0;
            end
        end
    end

    assign o_ex_stall  = (state_q == MA_REQ);
    assign dmem.req    = (state_q == MA_REQ);
    assign dmem.we     = we_q;
    assign dmem.addr   = addr_q;
    assign dmem.be     = be_q;
    assign dmem.wdata  = wdata_q;

    assign o_ma_valid      = ma_valid_q;
    assign o_ma_mem_to_reg = mem_to_reg_q;
    assign o_ma_rw_sel     = rw_sel_q;
    assign o_ma_result     = result_q;
    assign o_ma_read_data  = read_data_q;
    assign o_ma_pc_plus_4  = pc_plus_4_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access; expectations follow the
// MA_SUBWORD_EN build setting.
module tb_memory_access;
    import rv32i_pkg::*;

`ifdef MA_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_result = '0;
    logic [31:0] ex_store_data = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic        ex_mem_to_reg = 1'b0;
    logic [1:0]  ex_rw_sel = '0;
    logic [31:0] ex_pc_plus_4 = '0;
    logic        ex_stall;
    logic        ma_valid;
    logic        ma_mem_to_reg;
    logic [1:0]  ma_rw_sel;
    logic [31:0] ma_result;
    logic [31:0] ma_read_data;
    logic [31:0] ma_pc_plus_4;

    int n_checks = 0;
    int n_pass   = 0;

    memory_access_if dmem_bus ();

    always #5 clk = ~clk;

    memory_access dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_ex_valid      (ex_valid),
        .i_ex_result     (ex_result),
        .i_ex_store_data (ex_store_data),
        .i_ex_mem_read   (ex_mem_read),
        .i_ex_mem_write  (ex_mem_write),
        .i_ex_funct3     (ex_funct3),
        .i_ex_mem_to_reg (ex_mem_to_reg),
        .i_ex_rw_sel     (ex_rw_sel),
        .i_ex_pc_plus_4  (ex_pc_plus_4),
        .o_ex_stall      (ex_stall),
        .dmem            (dmem_bus),
        .o_ma_valid      (ma_valid),
        .o_ma_mem_to_reg (ma_mem_to_reg),
        .o_ma_rw_sel     (ma_rw_sel),
        .o_ma_result     (ma_result),
        .o_ma_read_data  (ma_read_data),
        .o_ma_pc_plus_4  (ma_pc_plus_4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] res, input logic [31:0] sd, input logic [31:0] pc,
                          input logic mtr, input logic [1:0] rws);
        ex_valid      = v;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_funct3     = f3;
        ex_result     = res;
        ex_store_data = sd;
        ex_pc_plus_4  = pc;
        ex_mem_to_reg = mtr;
        ex_rw_sel     = rws;
    endtask

    task automatic run_mem(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                           input int waits, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
        logic [31:0] exp_addr;
        int stalls;
        exp_addr = {a[31:2], 2'b00};
        stalls   = 0;
        set_ex(1'b1, rd, wr, f3, a, sd, 32'h0000_1000, rd, 2'd1);
        tick();
        // EX keeps driving a different instruction while stalled; it must be ignored.
        set_ex(1'b1, 1'b0, 1'b1, F3_W, 32'hFFFF_FFFC, 32'h5555_5555, 32'h0, 1'b0, 2'd3);
        check({tag, ".req"},   32'(dmem_bus.req), 32'd1);
        check({tag, ".we"},    32'(dmem_bus.we), 32'(wr));
        check({tag, ".addr"},  dmem_bus.addr, exp_addr);
        check({tag, ".be"},    32'(dmem_bus.be), 32'(exp_be));
        check({tag, ".wdata"}, dmem_bus.wdata, exp_wdata);
        check({tag, ".early_valid"}, 32'(ma_valid), 32'd0);
        for (int i = 0; i < waits; i++) begin
            if (ex_stall) stalls++;
            tick();
        end
        if (ex_stall) stalls++;
        check({tag, ".req_ack_cycle"}, 32'(dmem_bus.req), 32'd1);
        check({tag, ".addr_held"}, dmem_bus.addr, exp_addr);
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = rdat;
        tick();
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = 32'h0;
        ex_valid       = 1'b0;
        check({tag, ".valid"},     32'(ma_valid), 32'd1);
        check({tag, ".stall_off"}, 32'(ex_stall), 32'd0);
        check({tag, ".req_off"},   32'(dmem_bus.req), 32'd0);
        check({tag, ".read_data"}, ma_read_data, exp_rd);
        check({tag, ".result"},    ma_result, a);
        check({tag, ".stall_cyc"}, 32'(stalls), 32'(waits + 1));
        $display("txn %s addr=0x%08h be=%b wdata=0x%08h read_data=0x%08h stall=%0d",
                 tag, exp_addr, exp_be, exp_wdata, ma_read_data, stalls);
        tick();
        check({tag, ".valid_pulse"}, 32'(ma_valid), 32'd0);
    endtask

    initial begin
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst.valid",  32'(ma_valid), 32'd0);
        check("rst.stall",  32'(ex_stall), 32'd0);
        check("rst.req",    32'(dmem_bus.req), 32'd0);
        check("rst.addr",   dmem_bus.addr, 32'd0);
        check("rst.be",     32'(dmem_bus.be), 32'd0);
        check("rst.result", ma_result, 32'd0);
        check("rst.pc",     ma_pc_plus_4, 32'd0);
        $display("txn reset");
        rst_n = 1'b1;
        tick();

        // Non-memory instruction, latency 1
        set_ex(1'b1, 1'b0, 1'b0, F3_W, 32'h0000_0010, 32'h0, 32'h0000_0044, 1'b0, 2'd2);
        tick();
        ex_valid = 1'b0;
        check("add.valid",  32'(ma_valid), 32'd1);
        check("add.result", ma_result, 32'h0000_0010);
        check("add.pc",     ma_pc_plus_4, 32'h0000_0044);
        check("add.rw_sel", 32'(ma_rw_sel), 32'd2);
        check("add.rdata",  ma_read_data, 32'd0);
        check("add.req",    32'(dmem_bus.req), 32'd0);
        check("add.stall",  32'(ex_stall), 32'd0);
        $display("txn add result=0x%08h", ma_result);
        tick();
        check("add.pulse",  32'(ma_valid), 32'd0);
        check("add.req2",   32'(dmem_bus.req), 32'd0);

        // Back-to-back non-memory instructions
        set_ex(1'b1, 1'b0, 1'b0, F3_W, 32'h0000_0020, 32'h0, 32'h0000_0048, 1'b1, 2'd1);
        tick();
        check("b2b.valid1",  32'(ma_valid), 32'd1);
        check("b2b.result1", ma_result, 32'h0000_0020);
        check("b2b.mtr1",    32'(ma_mem_to_reg), 32'd1);
        set_ex(1'b1, 1'b0, 1'b0, F3_W, 32'h0000_0030, 32'h0, 32'h0000_004C, 1'b0, 2'd0);
        tick();
        ex_valid = 1'b0;
        check("b2b.valid2",  32'(ma_valid), 32'd1);
        check("b2b.result2", ma_result, 32'h0000_0030);
        check("b2b.pc2",     ma_pc_plus_4, 32'h0000_004C);
        $display("txn back_to_back result=0x%08h", ma_result);
        tick();

        run_mem("lb",  1'b1, 1'b0, F3_B,  32'h0000_0103, 32'h0, 32'h80FF_FF7F, 2,
                4'b1111, 32'h0, SUB ? 32'hFFFF_FF80 : 32'h80FF_FF7F);
        run_mem("sh",  1'b0, 1'b1, F3_H,  32'h0000_0202, 32'h0000_BEEF, 32'h1234_5678, 0,
                SUB ? 4'b1100 : 4'b1111, SUB ? 32'hBEEF_BEEF : 32'h0000_BEEF, 32'h0);
        run_mem("lhu", 1'b1, 1'b0, F3_HU, 32'h0000_0000, 32'h0, 32'h1234_8001, 1,
                4'b1111, 32'h0, SUB ? 32'h0000_8001 : 32'h1234_8001);
        run_mem("lh",  1'b1, 1'b0, F3_H,  32'h0000_0000, 32'h0, 32'h1234_8001, 0,
                4'b1111, 32'h0, SUB ? 32'hFFFF_8001 : 32'h1234_8001);
        run_mem("sb1", 1'b0, 1'b1, F3_B,  32'h0000_0001, 32'h0000_00AB, 32'h0, 0,
                SUB ? 4'b0010 : 4'b1111, SUB ? 32'hABAB_ABAB : 32'h0000_00AB, 32'h0);
        run_mem("sb3", 1'b0, 1'b1, F3_B,  32'h0000_0003, 32'h1234_5677, 32'h0, 1,
                SUB ? 4'b1000 : 4'b1111, SUB ? 32'h7777_7777 : 32'h1234_5677, 32'h0);
        run_mem("rw_both", 1'b1, 1'b1, F3_W, 32'h0000_0010, 32'hCAFE_F00D, 32'hFFFF_FFFF, 0,
                4'b1111, 32'hCAFE_F00D, 32'h0);
        run_mem("lw_mis", 1'b1, 1'b0, F3_W, 32'h0000_0307, 32'h0, 32'hDEAD_BEEF, 3,
                4'b1111, 32'h0, 32'hDEAD_BEEF);
        run_mem("lbu", 1'b1, 1'b0, F3_BU, 32'h0000_0002, 32'h0, 32'h00A5_0000, 0,
                4'b1111, 32'h0, SUB ? 32'h0000_00A5 : 32'h00A5_0000);

        // Reset while a request is outstanding, then a late ack
        set_ex(1'b1, 1'b1, 1'b0, F3_W, 32'h0000_0040, 32'h0, 32'h0, 1'b1, 2'd1);
        tick();
        ex_valid = 1'b0;
        check("rstreq.req_before", 32'(dmem_bus.req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstreq.req_async",   32'(dmem_bus.req), 32'd0);
        check("rstreq.stall_async", 32'(ex_stall), 32'd0);
        check("rstreq.addr_async",  dmem_bus.addr, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 32'h1111_1111;
        tick();
        dmem_bus.ack   = 1'b0;
        check("rstreq.no_valid", 32'(ma_valid), 32'd0);
        check("rstreq.idle",     32'(ex_stall), 32'd0);
        check("rstreq.req",      32'(dmem_bus.req), 32'd0);
        tick();
        check("rstreq.no_valid2", 32'(ma_valid), 32'd0);
        $display("txn reset_during_req");

        // Recovery after the abandoned request
        set_ex(1'b1, 1'b0, 1'b0, F3_W, 32'h0000_0055, 32'h0, 32'h0000_0058, 1'b0, 2'd0);
        tick();
        ex_valid = 1'b0;
        check("recover.valid",  32'(ma_valid), 32'd1);
        check("recover.result", ma_result, 32'h0000_0055);
        $display("txn recover result=0x%08h", ma_result);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
